program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
- Parametrised successor to the Hack program counter.
- Adds configurable address width, a step size, and a hardware call/return stack of DEPTH entries, with sticky overflow and underflow flags.
- Sits between the instruction decoder and instruction ROM; drives the fetch address every cycle.

Parameters:
- WIDTH, 16, bit width of PC, in_value and stack entries.
- DEPTH, 8, number of return-address stack entries (≥1).
- STEP, 1, amount added to the PC on increment; also the return-address offset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_value  input  WIDTH  jump/call target.
- load  input  1  jump: PC <= in_value.
- call  input  1  push PC+STEP, then PC <= in_value.
- ret  input  1  pop top of stack into PC.
- increment  input  1  PC <= PC+STEP.
- clear_err  input  1  clears the sticky error flags.
- out  output  WIDTH  current PC (registered).
- stack_depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- overflow  output  1  sticky: a call was made with the stack full.
- underflow  output  1  sticky: a ret was made with the stack empty.
- wrap_err  output  1  sticky: increment wrap detected (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out=0, stack_depth=0, overflow=0, underflow=0, wrap_err=0.
  - Stack contents are don't-care.
  - Deassertion takes effect at the next posedge.
- One action per posedge, strict priority: load > call > ret > increment > hold.
  - Lower-priority inputs asserted in the same cycle are ignored entirely: no stack change, no flag change.
- load: out <= in_value; stack untouched.
- call:
  - Not full: stack[depth] <= out+STEP; depth+1; out <= in_value.
  - Full (depth==DEPTH): the jump still happens; the push is discarded; depth stays DEPTH; overflow <= 1.
- ret:
  - Depth>0: out <= stack[depth-1]; depth-1.
  - Empty: out <= out+STEP (same as increment); underflow <= 1.
- increment: out <= out+STEP, modulo 2^WIDTH.
- Hold: no action inputs asserted → all state unchanged.
- Latency: all outputs are registered; a new PC is visible one cycle after the action edge.
- Arithmetic: all sums are truncated to WIDTH bits; the return address also wraps (max+STEP wraps).
- clear_err:
  - Clears overflow, underflow and wrap_err on that edge.
  - If an error-setting event occurs on the same edge, set wins.
  - Does not affect PC or stack.
- Reset mid-sequence: the stack is emptied asynchronously; pending inputs on the reset edge are ignored.

Optional Feature:
- Macro PC_WRAP_TRAP_EN.
- Defined:
  - An increment (or empty-ret fallback) for which out+STEP overflows WIDTH bits leaves out unchanged and sets wrap_err.
  - A call with an overflowing return address still jumps; the truncated address is pushed and wrap_err is set.
- Undefined: the PC wraps silently modulo 2^WIDTH; wrap_err is tied to 0.

Test Plan:
- WIDTH=16, STEP=1; reset, then increment for 3 cycles → out=0,1,2,3; then assert reset_n=0 mid-cycle → out=0 immediately, stack_depth=0.
- From out=0x0010: call in_value=0x0100 → out=0x0100, depth=1; increment ×2 → 0x0102; ret → out=0x0011, depth=0.
- DEPTH=8: nine nested calls to 0x0200+i → depth=8, overflow=1 after the ninth, out=0x0208; eight rets return in LIFO order; a ninth ret → underflow=1, out=previous+1.
- Same cycle load=1, call=1, ret=1, increment=1, in_value=0x1234, out=0x0040 → out=0x1234, depth unchanged, flags unchanged.
- out=0xFFFF, increment → without PC_WRAP_TRAP_EN: out=0x0000, wrap_err=0; with it: out=0xFFFF, wrap_err=1; then clear_err → wrap_err=0.
- STEP=2, WIDTH=12: out=0x7FE, call 0x100 → pushed 0x800, out=0x100; ret → out=0x800.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with step-size increment, a DEPTH-entry call/return stack and sticky error flags.
// Optional feature macro: PC_WRAP_TRAP_EN (trap on PC/return-address wrap instead of wrapping silently).
module program_counter_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_value,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             increment,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    stack_depth,
  output logic             overflow,
  output logic             underflow,
  output logic             wrap_err
);

`ifdef PC_WRAP_TRAP_EN
  localparam bit WRAP_TRAP = 1'b1;
`else
  localparam bit WRAP_TRAP = 1'b0;
`endif

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, unf_q, wrap_q;
  logic             ovf_set, unf_set, wrap_set;
  logic             push;
  logic [WIDTH:0]   pc_plus;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  // Extra MSB of the sum is the wrap indicator for both increment and return address.
  assign pc_plus  = {1'b0, pc_q} + (WIDTH + 1)'(STEP);
  assign push_idx = AW'(depth_q);
  assign pop_idx  = AW'(depth_q - DW'(1));

  always_comb begin
    pc_d     = pc_q;
    depth_d  = depth_q;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    wrap_set = 1'b0;
    push     = 1'b0;
    if (load) begin
      pc_d = in_value;
    end else if (call) begin
      pc_d     = in_value;
      wrap_set = WRAP_TRAP && pc_plus[WIDTH];
      if (depth_q == FULL) begin
        ovf_set = 1'b1;
      end else begin
        push    = 1'b1;
        depth_d = depth_q + DW'(1);
      end
    end else if (ret && (depth_q != '0)) begin
      pc_d    = stack_mem[pop_idx];
      depth_d = depth_q - DW'(1);
    end else if (ret || increment) begin
      // Empty ret falls back to an increment and additionally flags underflow.
      unf_set = ret;
      if (WRAP_TRAP && pc_plus[WIDTH]) begin
        wrap_set = 1'b1;
      end else begin
        pc_d = pc_plus[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      // Set beats clear when both happen on the same edge.
      ovf_q   <= ovf_set  | (ovf_q  & ~clear_err);
      unf_q   <= unf_set  | (unf_q  & ~clear_err);
      wrap_q  <= wrap_set | (wrap_q & ~clear_err);
    end
  end

  // Stack contents need no reset; only entries below depth_q are ever read.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= pc_plus[WIDTH-1:0];
  end

  assign out         = pc_q;
  assign stack_depth = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign wrap_err    = wrap_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack: default instance (16b/8 deep/step 1) and a 12b/step 2 instance.
module tb_program_counter_stack;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_in;
  logic        a_load, a_call, a_ret, a_inc, a_clr;
  logic [15:0] a_out;
  logic [3:0]  a_depth;
  logic        a_ovf, a_unf, a_wrap;

  logic [11:0] b_in;
  logic        b_load, b_call, b_ret, b_inc, b_clr;
  logic [11:0] b_out;
  logic [1:0]  b_depth;
  logic        b_ovf, b_unf, b_wrap;

  int errors = 0;
  int checks = 0;

  program_counter_stack #(.WIDTH(16), .DEPTH(8), .STEP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_value(a_in), .load(a_load), .call(a_call),
    .ret(a_ret), .increment(a_inc), .clear_err(a_clr), .out(a_out),
    .stack_depth(a_depth), .overflow(a_ovf), .underflow(a_unf), .wrap_err(a_wrap)
  );

  program_counter_stack #(.WIDTH(12), .DEPTH(2), .STEP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_value(b_in), .load(b_load), .call(b_call),
    .ret(b_ret), .increment(b_inc), .clear_err(b_clr), .out(b_out),
    .stack_depth(b_depth), .overflow(b_ovf), .underflow(b_unf), .wrap_err(b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_in = '0; a_load = 0; a_call = 0; a_ret = 0; a_inc = 0; a_clr = 0;
    b_in = '0; b_load = 0; b_call = 0; b_ret = 0; b_inc = 0; b_clr = 0;
  endtask

  // Apply current inputs for one edge, sample 1 time unit later, then drop inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic a_do(input logic l, input logic c, input logic r, input logic i,
                      input logic clr, input logic [15:0] v);
    a_load = l; a_call = c; a_ret = r; a_inc = i; a_clr = clr; a_in = v;
    tick();
  endtask

  task automatic a_state(input string tag, input logic [15:0] pc, input logic [3:0] d,
                         input logic ov, input logic un);
    check({tag, ".out"}, 32'(a_out), 32'(pc));
    check({tag, ".depth"}, 32'(a_depth), 32'(d));
    check({tag, ".ovf"}, 32'(a_ovf), 32'(ov));
    check({tag, ".unf"}, 32'(a_unf), 32'(un));
  endtask

  initial begin
    idle();
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    a_state("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    check("reset.wrap", 32'(a_wrap), 32'd0);
    check("reset.b_out", 32'(b_out), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset.out", 32'(a_out), 32'd0);

    // Increment sequence and asynchronous reset mid-cycle
    a_do(0, 0, 0, 1, 0, 16'h0); check("inc1", 32'(a_out), 32'h1);
    a_do(0, 0, 0, 1, 0, 16'h0); check("inc2", 32'(a_out), 32'h2);
    a_do(0, 0, 0, 1, 0, 16'h0); check("inc3", 32'(a_out), 32'h3);
    a_do(0, 1, 0, 0, 0, 16'h0050); a_state("pre_rst_call", 16'h0050, 4'd1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst.out", 32'(a_out), 32'd0);
    check("async_rst.depth", 32'(a_depth), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Call / increment / return
    a_do(1, 0, 0, 0, 0, 16'h0010); check("load", 32'(a_out), 32'h0010);
    a_do(0, 1, 0, 0, 0, 16'h0100); a_state("call", 16'h0100, 4'd1, 1'b0, 1'b0);
    a_do(0, 0, 0, 1, 0, 16'h0); a_do(0, 0, 0, 1, 0, 16'h0);
    check("call_inc2", 32'(a_out), 32'h0102);
    a_do(0, 0, 1, 0, 0, 16'h0); a_state("ret", 16'h0011, 4'd0, 1'b0, 1'b0);

    // Nine nested calls: last one overflows the 8-deep stack
    for (int i = 0; i < 8; i++) a_do(0, 1, 0, 0, 0, 16'h0200 + 16'(i));
    a_state("call8", 16'h0207, 4'd8, 1'b0, 1'b0);
    a_do(0, 1, 0, 0, 0, 16'h0208); a_state("call9_ovf", 16'h0208, 4'd8, 1'b1, 1'b0);
    for (int i = 7; i >= 1; i--) begin
      a_do(0, 0, 1, 0, 0, 16'h0);
      check("lifo_ret", 32'(a_out), 32'h0200 + 32'(i));
    end
    a_do(0, 0, 1, 0, 0, 16'h0); a_state("ret8", 16'h0012, 4'd0, 1'b1, 1'b0);
    a_do(0, 0, 1, 0, 0, 16'h0); a_state("ret9_unf", 16'h0013, 4'd0, 1'b1, 1'b1);
    a_do(0, 0, 0, 0, 0, 16'h0); a_state("hold", 16'h0013, 4'd0, 1'b1, 1'b1);

    // clear_err, and set-wins when a new underflow lands on the same edge
    a_do(0, 0, 1, 0, 1, 16'h0); a_state("clr_set_wins", 16'h0014, 4'd0, 1'b0, 1'b1);
    a_do(0, 0, 0, 0, 1, 16'h0); a_state("clr", 16'h0014, 4'd0, 1'b0, 1'b0);

    // Priority: load beats everything; call beats ret
    a_do(0, 1, 0, 0, 0, 16'h0040); a_state("call40", 16'h0040, 4'd1, 1'b0, 1'b0);
    a_do(1, 1, 1, 1, 0, 16'h1234); a_state("prio_load", 16'h1234, 4'd1, 1'b0, 1'b0);
    a_do(0, 1, 1, 1, 0, 16'h0300); a_state("prio_call", 16'h0300, 4'd2, 1'b0, 1'b0);
    a_do(0, 0, 1, 1, 0, 16'h0); a_state("prio_ret", 16'h1235, 4'd1, 1'b0, 1'b0);
    a_do(0, 0, 1, 0, 0, 16'h0); a_state("prio_ret2", 16'h0015, 4'd0, 1'b0, 1'b0);

    // PC wrap on increment, return address wrap on call
    a_do(1, 0, 0, 0, 0, 16'hFFFF);
    a_do(0, 0, 0, 1, 0, 16'h0);
`ifdef PC_WRAP_TRAP_EN
    check("wrap_inc.out", 32'(a_out), 32'hFFFF);
    check("wrap_inc.wrap", 32'(a_wrap), 32'd1);
`else
    check("wrap_inc.out", 32'(a_out), 32'h0000);
    check("wrap_inc.wrap", 32'(a_wrap), 32'd0);
`endif
    a_do(0, 0, 0, 0, 1, 16'h0); check("wrap_clr", 32'(a_wrap), 32'd0);
    a_do(1, 0, 0, 0, 0, 16'hFFFF);
    a_do(0, 1, 0, 0, 0, 16'h0005);
    a_state("wrap_call", 16'h0005, 4'd1, 1'b0, 1'b0);
`ifdef PC_WRAP_TRAP_EN
    check("wrap_call.wrap", 32'(a_wrap), 32'd1);
`else
    check("wrap_call.wrap", 32'(a_wrap), 32'd0);
`endif
    a_do(0, 0, 1, 0, 0, 16'h0); a_state("wrap_ret", 16'h0000, 4'd0, 1'b0, 1'b0);

    // 12-bit, step 2 instance
    b_load = 1; b_in = 12'h7FE; tick();
    check("b_load", 32'(b_out), 32'h7FE);
    b_call = 1; b_in = 12'h100; tick();
    check("b_call.out", 32'(b_out), 32'h100);
    check("b_call.depth", 32'(b_depth), 32'd1);
    b_inc = 1; tick();
    check("b_inc", 32'(b_out), 32'h102);
    b_ret = 1; tick();
    check("b_ret.out", 32'(b_out), 32'h800);
    check("b_ret.depth", 32'(b_depth), 32'd0);
    b_load = 1; b_in = 12'hFFE; tick();
    b_inc = 1; tick();
`ifdef PC_WRAP_TRAP_EN
    check("b_wrap.out", 32'(b_out), 32'hFFE);
    check("b_wrap.wrap", 32'(b_wrap), 32'd1);
`else
    check("b_wrap.out", 32'(b_out), 32'h000);
    check("b_wrap.wrap", 32'(b_wrap), 32'd0);
`endif
    check("b_flags", 32'({b_ovf, b_unf}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
